// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receive checker: acquires lock by loading received bits
// into a local LFSR, then free-runs it and reports per-bit errors and loss of lock.
module prbs_checker #(
    parameter int SIZE           = 8,
    parameter int TAP1           = 7,
    parameter int TAP2           = 6,
    parameter int LOCK_COUNT     = 16,
    parameter int WINDOW         = 64,
    parameter int LOSS_THRESHOLD = 4,
    parameter int COUNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               prbs_in,
    input  logic               clear_errors,
    output logic               locked,
    output logic               error,
    output logic [COUNT_W-1:0] error_count
);

    localparam int FILL_W  = $clog2(SIZE + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W  = $clog2(LOSS_THRESHOLD + 1);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [SIZE-1:0]    sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               error_q, error_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               expected;
    logic               mismatch;
    logic               seeded;
    logic [MATCH_W-1:0] match_inc;
    logic [WERR_W-1:0]  werr_inc;

    assign expected  = sr_q[TAP1] ^ sr_q[TAP2];
    assign mismatch  = prbs_in != expected;
    assign seeded    = sr_q != '0;
    assign match_inc = match_q + MATCH_W'(1);
    assign werr_inc  = werr_q + WERR_W'(mismatch);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        count_d = count_q;
        error_d = 1'b0;

        if (enable) begin
            case (state_q)
                SEARCH: begin
                    sr_d = {sr_q[SIZE-2:0], prbs_in};
                    if (fill_q != FILL_W'(SIZE)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (seeded && !mismatch) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    sr_d = {sr_q[SIZE-2:0], expected};
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + COUNT_W'(1);
                        end
                    end
                    // Loss is tested before the window wrap; sr is kept, so fill stays satisfied.
                    if (werr_inc == WERR_W'(LOSS_THRESHOLD)) begin
                        state_d = SEARCH;
                        match_d = '0;
                    end else if (win_q == WIN_W'(WINDOW - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WIN_W'(1);
                        werr_d = werr_inc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clear_errors) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            sr_q    <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign error       = error_q;
    assign error_count = count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural model predicts outputs per valid
// bit, a monitor pops and compares them after each edge.
module tb_prbs_checker;

    localparam int SIZE       = 8;
    localparam int TAP1       = 7;
    localparam int TAP2       = 6;
    localparam int LOCK_COUNT = 16;
    localparam int WINDOW     = 64;
    localparam int LOSS       = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        prbs_in = 1'b0;
    logic        clear_errors = 1'b0;
    logic        locked, error;
    logic [15:0] error_count;
    logic        locked4, error4;
    logic [3:0]  error_count4;

    always #5 clock = ~clock;

    prbs_checker #(
        .SIZE(SIZE), .TAP1(TAP1), .TAP2(TAP2), .LOCK_COUNT(LOCK_COUNT),
        .WINDOW(WINDOW), .LOSS_THRESHOLD(LOSS), .COUNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .prbs_in(prbs_in),
        .clear_errors(clear_errors), .locked(locked), .error(error),
        .error_count(error_count)
    );

    prbs_checker #(
        .SIZE(SIZE), .TAP1(TAP1), .TAP2(TAP2), .LOCK_COUNT(LOCK_COUNT),
        .WINDOW(WINDOW), .LOSS_THRESHOLD(LOSS), .COUNT_W(4)
    ) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .prbs_in(prbs_in),
        .clear_errors(clear_errors), .locked(locked4), .error(error4),
        .error_count(error_count4)
    );

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    logic [7:0] gen;

    // Reference model: history of the last SIZE bits, newest at index 0.
    bit hist[$];
    int m_locked, m_fill, m_match, m_win, m_werr, m_cnt, m_cnt4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < SIZE; i++) hist.push_back(1'b0);
        m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_cnt = 0; m_cnt4 = 0;
    endfunction

    function automatic exp_t model_step(input bit b, input bit clr);
        exp_t e;
        bit   ex = hist[TAP1] ^ hist[TAP2];
        bit   nz = 1'b0;
        bit   bad = 1'b0;
        foreach (hist[i]) if (hist[i]) nz = 1'b1;
        if (m_locked == 0) begin
            if (m_fill == SIZE) begin
                if (nz && b == ex) m_match++;
                else m_match = 0;
            end else begin
                m_fill++;
            end
            hist.push_front(b);
            void'(hist.pop_back());
            if (m_match == LOCK_COUNT) begin
                m_locked = 1; m_match = 0; m_win = 0; m_werr = 0;
            end
        end else begin
            hist.push_front(ex);
            void'(hist.pop_back());
            if (b != ex) begin
                bad = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
                m_werr++;
            end
            if (m_werr == LOSS) begin
                m_locked = 0; m_match = 0;
            end else if (m_win == WINDOW - 1) begin
                m_win = 0; m_werr = 0;
            end else begin
                m_win++;
            end
        end
        if (clr) begin
            m_cnt = 0; m_cnt4 = 0;
        end
        e.locked = (m_locked != 0);
        e.err    = bad;
        e.cnt    = 16'(m_cnt);
        e.cnt4   = 4'(m_cnt4);
        return e;
    endfunction

    function automatic bit gen_next();
        bit b = gen[TAP1] ^ gen[TAP2];
        gen = {gen[6:0], b};
        return b;
    endfunction

    logic en_seen = 1'b0;
    always @(posedge clock or posedge reset) begin
        if (reset) en_seen <= 1'b0;
        else       en_seen <= enable;
    end

    always @(negedge clock) begin
        exp_t e;
        if (error === 1'b1) err_pulses++;
        if (en_seen) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("locked", 32'(locked), 32'(e.locked));
                check("error", 32'(error), 32'(e.err));
                check("error_count", 32'(error_count), 32'(e.cnt));
                check("locked4", 32'(locked4), 32'(e.locked));
                check("error4", 32'(error4), 32'(e.err));
                check("error_count4", 32'(error_count4), 32'(e.cnt4));
            end
        end else if (!reset) begin
            check("idle_error", 32'(error), 32'd0);
            check("idle_error4", 32'(error4), 32'd0);
        end
    end

    task automatic send(input bit b, input bit en, input bit clr);
        prbs_in      = b;
        enable       = en;
        clear_errors = clr;
        if (en) sb_q.push_back(model_step(b, clr));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        clear_errors = 1'b0;
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(error_count), 32'd0);
        check("rst_count4", 32'(error_count4), 32'd0);
        sb_q.delete();
        model_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        err_pulses = 0;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    initial begin
        bit b, en, clr;
        #1;
        do_reset();

        // Clean stream: lock on the 24th bit, no errors.
        gen = 8'h0F;
        for (int i = 0; i < 200; i++) begin
            send(gen_next(), 1'b1, 1'b0);
            if (i == 22) check("t1_prelock", 32'(locked), 32'd0);
            if (i == 23) check("t1_lock24", 32'(locked), 32'd1);
        end
        settle();
        check("t1_pulses", 32'(err_pulses), 32'd0);
        check("t1_count", 32'(error_count), 32'd0);

        // Single inverted bit gives exactly one error.
        do_reset();
        gen = 8'h0F;
        for (int i = 0; i < 200; i++) begin
            b = gen_next();
            send(b ^ (i == 99), 1'b1, 1'b0);
        end
        settle();
        check("t2_pulses", 32'(err_pulses), 32'd1);
        check("t2_count", 32'(error_count), 32'd1);
        check("t2_locked", 32'(locked), 32'd1);

        // Four errors in one window drop lock; 16 clean bits re-acquire.
        do_reset();
        gen = 8'h0F;
        repeat (40) send(gen_next(), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            b = gen_next();
            send(b ^ (i % 5 == 0), 1'b1, 1'b0);
        end
        check("t3_lost", 32'(locked), 32'd0);
        for (int j = 0; j < 16; j++) begin
            send(gen_next(), 1'b1, 1'b0);
            if (j == 14) check("t3_relock15", 32'(locked), 32'd0);
            if (j == 15) check("t3_relock16", 32'(locked), 32'd1);
        end
        settle();
        check("t3_pulses", 32'(err_pulses), 32'd4);
        check("t3_count", 32'(error_count), 32'd4);

        // All-zero input never locks, then a real stream does.
        do_reset();
        repeat (100) send(1'b0, 1'b1, 1'b0);
        check("t4_zero_lock", 32'(locked), 32'd0);
        check("t4_zero_count", 32'(error_count), 32'd0);
        gen = 8'h0F;
        repeat (40) send(gen_next(), 1'b1, 1'b0);
        check("t4_lock", 32'(locked), 32'd1);

        // Three errors per window: no loss, 4-bit count saturates, clear wins.
        do_reset();
        gen = 8'h0F;
        repeat (24) send(gen_next(), 1'b1, 1'b0);
        check("t5_lock", 32'(locked), 32'd1);
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < WINDOW; i++) begin
                b = gen_next();
                send(b ^ (i == 10 || i == 20 || i == 30), 1'b1, 1'b0);
            end
        end
        check("t5_sat4", 32'(error_count4), 32'hF);
        check("t5_count", 32'(error_count), 32'd24);
        check("t5_locked", 32'(locked), 32'd1);
        b = gen_next();
        send(~b, 1'b1, 1'b1);
        check("t5_clr_err", 32'(error), 32'd1);
        check("t5_clr_count", 32'(error_count), 32'd0);
        check("t5_clr_count4", 32'(error_count4), 32'd0);

        // Every other cycle idle: lock after 24 valid bits, 47 cycles in.
        do_reset();
        gen = 8'h0F;
        for (int i = 0; i < 48; i++) begin
            if (i % 2 == 0) send(gen_next(), 1'b1, 1'b0);
            else            send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (i == 45) check("t6_prelock", 32'(locked), 32'd0);
            if (i == 46) check("t6_lock", 32'(locked), 32'd1);
        end
        b = gen_next();
        send(~b, 1'b1, 1'b0);
        check("t6_err_pre_rst", 32'(error), 32'd1);
        check("t6_cnt_pre_rst", 32'(error_count), 32'd1);
        do_reset();

        // Randomised soak: gaps, sparse line errors, occasional clears.
        gen = 8'h0F;
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = en && ($urandom_range(0, 99) == 0);
            if (en) begin
                b = gen_next();
                send(b ^ ($urandom_range(0, 39) == 0), 1'b1, clr);
            end else begin
                send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
        settle();
        check("soak_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
